// File: rtl/led_flash_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_flash_pkg                                                 |
// | Purpose  : Shared state encoding and tick-period helper for the LED      |
// |            flash controller and its 10 ms tick source.                   |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package led_flash_pkg;

  // Controller state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  // Terminal value of a cycle counter that wraps once per 10 ms
  function automatic logic [31:0] t10ms_max(input logic [63:0] ref_clk);
    return 32'(ref_clk / 64'd100 - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen_10ms.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tick_gen_10ms                                                 |
// | Purpose  : Free-running 10 ms tick source; clearable so that a timed     |
// |            sequence can start on an exact period boundary.               |
// | Ports    : I_sysclk - system clock                                       |
// |            I_rstn   - asynchronous active-low reset                      |
// |            I_clr    - restart the period (counter to 0 next cycle)       |
// |            O_tick   - high for one cycle at the end of each period       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tick_gen_10ms
  import led_flash_pkg::*;
#(
  parameter logic [63:0] REF_CLK = 64'd50_000_000
) (
  input  logic I_sysclk,
  input  logic I_rstn,
  input  logic I_clr,
  output logic O_tick
);

  localparam logic [31:0] c_T10MS = t10ms_max(REF_CLK);

  logic [31:0] r_cyc_cnt;

  always_ff @(posedge I_sysclk or negedge I_rstn) begin
    if (!I_rstn) begin
      r_cyc_cnt <= '0;
    end else if (I_clr || (r_cyc_cnt == c_T10MS)) begin
      r_cyc_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
    end
  end

  assign O_tick = (r_cyc_cnt == c_T10MS);

endmodule
`default_nettype wire

// File: rtl/led_flash_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_flash_ctrl                                                |
// | Purpose  : Flashes a board LED N times per single-cycle command pulse,   |
// |            with on/off phase lengths in 10 ms ticks.                     |
// | Ports    : I_sysclk - system clock                                       |
// |            I_rstn   - asynchronous active-low reset                      |
// |            I_trig   - start pulse, only honoured while idle              |
// |            I_count  - flash count latched at acceptance (0 = no-op)      |
// |            I_abort  - forces idle on the next cycle                      |
// |            O_led    - registered LED drive (polarity by LED_ACT_LOW)     |
// |            O_busy   - burst in progress                                  |
// |            O_done   - one-cycle pulse after the last on-phase            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module led_flash_ctrl
  import led_flash_pkg::*;
#(
  parameter logic [63:0] REF_CLK     = 64'd50_000_000,
  parameter logic [7:0]  ON_TICKS    = 8'd20,
  parameter logic [7:0]  OFF_TICKS   = 8'd20,
  parameter logic        LED_ACT_LOW = 1'b0
) (
  input  logic       I_sysclk,
  input  logic       I_rstn,
  input  logic       I_trig,
  input  logic [3:0] I_count,
  input  logic       I_abort,
  output logic       O_led,
  output logic       O_busy,
  output logic       O_done
);

  localparam logic [7:0] c_ON_LAST  = ON_TICKS - 8'd1;
  localparam logic [7:0] c_OFF_LAST = OFF_TICKS - 8'd1;
  localparam logic       c_LED_ON   = ~LED_ACT_LOW;
  localparam logic       c_LED_OFF  = LED_ACT_LOW;

  logic [1:0] r_state;
  logic [7:0] r_ph_cnt;
  logic [3:0] r_rem;
  logic       w_tick;
  logic       w_accept;

  assign w_accept = (r_state == S_IDLE) && I_trig && (I_count != 4'd0) && !I_abort;

  // Restarting the tick period on acceptance makes the first on-phase exact
  tick_gen_10ms #(
    .REF_CLK (REF_CLK)
  ) u_tick_gen (
    .I_sysclk (I_sysclk),
    .I_rstn   (I_rstn),
    .I_clr    (w_accept),
    .O_tick   (w_tick)
  );

  always_ff @(posedge I_sysclk or negedge I_rstn) begin
    if (!I_rstn) begin
      r_state  <= S_IDLE;
      r_ph_cnt <= '0;
      r_rem    <= '0;
      O_led    <= c_LED_OFF;
      O_busy   <= 1'b0;
      O_done   <= 1'b0;
    end else begin
      O_done <= 1'b0;
      if (I_abort) begin
        r_state  <= S_IDLE;
        r_ph_cnt <= '0;
        r_rem    <= '0;
        O_led    <= c_LED_OFF;
        O_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_state  <= S_ON;
              r_ph_cnt <= '0;
              r_rem    <= I_count;
              O_led    <= c_LED_ON;
              O_busy   <= 1'b1;
            end
          end
          S_ON: begin
            if (w_tick) begin
              if (r_ph_cnt == c_ON_LAST) begin
                r_ph_cnt <= '0;
                O_led    <= c_LED_OFF;
                // Last flash ends the burst with no trailing off-gap
                if (r_rem == 4'd1) begin
                  r_state <= S_IDLE;
                  r_rem   <= '0;
                  O_busy  <= 1'b0;
                  O_done  <= 1'b1;
                end else begin
                  r_state <= S_OFF;
                  r_rem   <= r_rem - 4'd1;
                end
              end else begin
                r_ph_cnt <= r_ph_cnt + 8'd1;
              end
            end
          end
          S_OFF: begin
            if (w_tick) begin
              if (r_ph_cnt == c_OFF_LAST) begin
                r_state  <= S_ON;
                r_ph_cnt <= '0;
                O_led    <= c_LED_ON;
              end else begin
                r_ph_cnt <= r_ph_cnt + 8'd1;
              end
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_ph_cnt <= '0;
            r_rem    <= '0;
            O_led    <= c_LED_OFF;
            O_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_flash_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_led_flash_ctrl                                             |
// | Purpose  : Directed self-checking bench for led_flash_ctrl. Two DUTs     |
// |            share stimulus: one active-high LED, one active-low LED.      |
// |            Tick every 10 cycles, ON=20 cycles, OFF=30 cycles.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_led_flash_ctrl;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       trig  = 1'b0;
  logic [3:0] count = 4'd0;
  logic       abort = 1'b0;

  logic led_h, busy_h, done_h;
  logic led_l, busy_l, done_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_flash_ctrl #(
    .REF_CLK     (64'd1000),
    .ON_TICKS    (8'd2),
    .OFF_TICKS   (8'd3),
    .LED_ACT_LOW (1'b0)
  ) u_dut_h (
    .I_sysclk (clk),
    .I_rstn   (rstn),
    .I_trig   (trig),
    .I_count  (count),
    .I_abort  (abort),
    .O_led    (led_h),
    .O_busy   (busy_h),
    .O_done   (done_h)
  );

  led_flash_ctrl #(
    .REF_CLK     (64'd1000),
    .ON_TICKS    (8'd2),
    .OFF_TICKS   (8'd3),
    .LED_ACT_LOW (1'b1)
  ) u_dut_l (
    .I_sysclk (clk),
    .I_rstn   (rstn),
    .I_trig   (trig),
    .I_count  (count),
    .I_abort  (abort),
    .O_led    (led_l),
    .O_busy   (busy_l),
    .O_done   (done_l)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flash i (0-based) is lit in cycles 1+50i .. 20+50i after the trigger cycle
  function automatic logic exp_led(input int n, input int c);
    for (int i = 0; i < n; i++) begin
      if (c >= 1 + 50 * i && c <= 20 + 50 * i) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int last_busy(input int n);
    return 20 + 50 * (n - 1);
  endfunction

  // Trigger a burst of n flashes in the current cycle (cycle 0) and check
  // cycles 1..ncyc. Optional second trigger (count 5) at t2_cyc and abort at
  // abort_cyc (0 disables either). I_count is scrambled after cycle 0.
  task automatic burst(input string name, input int n, input int ncyc,
                       input int t2_cyc, input int abort_cyc);
    logic el, eb, ed, gone;
    trig  = 1'b1;
    count = 4'(n);
    abort = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      gone = (abort_cyc > 0) && (c > abort_cyc);
      el = gone ? 1'b0 : exp_led(n, c);
      eb = gone ? 1'b0 : (c >= 1 && c <= last_busy(n));
      ed = gone ? 1'b0 : (c == last_busy(n) + 1);
      check($sformatf("%s led c=%0d", name, c), led_h, el);
      check($sformatf("%s led_al c=%0d", name, c), led_l, ~el);
      check($sformatf("%s busy c=%0d", name, c), busy_h, eb);
      check($sformatf("%s done c=%0d", name, c), done_h, ed);
      trig  = (c == t2_cyc);
      count = (c == t2_cyc) ? 4'd5 : 4'd15;
      abort = (c == abort_cyc);
    end
    trig  = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_idle(input string name, input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      step();
      check($sformatf("%s led c=%0d", name, c), led_h, 1'b0);
      check($sformatf("%s led_al c=%0d", name, c), led_l, 1'b1);
      check($sformatf("%s busy c=%0d", name, c), busy_h, 1'b0);
      check($sformatf("%s done c=%0d", name, c), done_h, 1'b0);
    end
  endtask

  initial begin
    // Reset values
    rstn = 1'b0;
    repeat (3) step();
    check("rst led", led_h, 1'b0);
    check("rst led_al", led_l, 1'b1);
    check("rst busy", busy_h, 1'b0);
    check("rst done", done_h, 1'b0);
    check("rst busy_al", busy_l, 1'b0);
    check("rst done_al", done_l, 1'b0);
    rstn = 1'b1;
    step();

    // Three-flash burst, run past completion
    burst("n3", 3, 130, 0, 0);

    // Zero count is a no-op
    burst("n0", 0, 200, 0, 0);

    // Trigger while busy is ignored
    burst("n2_retrig", 2, 100, 10, 0);

    // Abort mid-flash, then a fresh single flash
    burst("n4_abort", 4, 79, 0, 60);
    burst("n1_after_abort", 1, 40, 0, 0);

    // Abort and trigger together: abort wins
    trig  = 1'b1;
    count = 4'd3;
    abort = 1'b1;
    step();
    trig  = 1'b0;
    abort = 1'b0;
    check("trig_abort led", led_h, 1'b0);
    check("trig_abort busy", busy_h, 1'b0);
    check_idle("trig_abort", 30);

    // Back-to-back single flashes, each triggered in the done cycle
    burst("b2b0", 1, 21, 0, 0);
    burst("b2b1", 1, 21, 0, 0);
    burst("b2b2", 1, 21, 0, 0);
    burst("b2b3", 1, 40, 0, 0);

    // Reset mid-burst: outputs fall without waiting for a clock edge
    burst("n3_rst", 3, 35, 0, 0);
    rstn = 1'b0;
    #2;
    check("async_rst led", led_h, 1'b0);
    check("async_rst led_al", led_l, 1'b1);
    check("async_rst busy", busy_h, 1'b0);
    check("async_rst busy_al", busy_l, 1'b0);
    check("async_rst done", done_h, 1'b0);
    repeat (3) step();
    rstn = 1'b1;
    check_idle("post_rst", 80);

    // Still functional after reset release
    burst("n1_post_rst", 1, 30, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_flash_ctrl.md
Name: led_flash_ctrl

Overview:
- Output-side counterpart to the debounced push-button input: drives a board LED with a burst of N timed flashes per single-cycle command pulse.
- Typical use: confirm a key press or AE-setting change, e.g. by flashing the LED once per step.
- Sits between control logic (pulse sources such as key-down events) and the LED pin.
- All timing is in 10 ms ticks derived from the system clock.

Parameters:
- REF_CLK, 64'd50_000_000, system clock frequency in Hz; T10MS = REF_CLK/100 - 1.
- ON_TICKS, 8'd20, LED-on time per flash in 10 ms units; legal range 1..255.
- OFF_TICKS, 8'd20, LED-off gap between flashes in 10 ms units; legal range 1..255.
- LED_ACT_LOW, 1'b0, 1 = LED pin is active-low (O_led inverted at the output register).

Ports:
- I_sysclk  in  1  system clock; the only clock.
- I_rstn  in  1  asynchronous, active-low reset.
- I_trig  in  1  single-cycle start pulse; sampled only in IDLE.
- I_count  in  4  number of flashes, latched with the accepted I_trig; 0 = no-op.
- I_abort  in  1  level or pulse; forces IDLE immediately.
- O_led  out  1  LED drive, registered; polarity set by LED_ACT_LOW.
- O_busy  out  1  high from the cycle after acceptance until return to IDLE.
- O_done  out  1  one-cycle pulse when the final flash's on-phase completes normally.

Behaviour:
- Reset: one clock, I_sysclk; asynchronous active-low reset I_rstn.
  - Values during reset: state=IDLE, O_led=inactive level (0, or 1 if LED_ACT_LOW), O_busy=0, O_done=0, all counters 0.
- Tick generator:
  - cyc_cnt (32 bit) counts 0..T10MS and wraps.
  - tick = (cyc_cnt == T10MS).
  - cyc_cnt is cleared to 0 on an accepted trigger, so the first phase length is exact.
- Acceptance: cycle t with state=IDLE, I_trig=1, I_count!=0, I_abort=0.
  - At t+1: state=ON, O_led active, O_busy=1, rem=I_count, ph_cnt=0.
- States IDLE, ON, OFF.
  - ON: ph_cnt increments on each tick. On the tick where ph_cnt==ON_TICKS-1:
    - if rem==1: go to IDLE. O_led goes inactive, O_busy=0 and O_done=1, all in the same next cycle.
    - else: rem-=1, go to OFF, O_led goes inactive, ph_cnt=0.
  - OFF: on the tick where ph_cnt==OFF_TICKS-1, go to ON, O_led goes active, ph_cnt=0.
- Exact durations: on-phase = ON_TICKS*(T10MS+1) cycles; off-phase = OFF_TICKS*(T10MS+1) cycles.
- Total busy time = N*ON + (N-1)*OFF cycles. There is no trailing off-gap.
- I_trig while busy: ignored. No queueing; busy and LED timing are unaffected.
- I_count==0 with I_trig: ignored. State stays IDLE; no busy, no done.
- I_abort=1 in any state: next cycle state=IDLE, O_led inactive, O_busy=0. No O_done.
- I_trig and I_abort in the same cycle: abort wins and the trigger is dropped.
- I_trig in the cycle O_done is asserted (state already IDLE): accepted normally, allowing back-to-back bursts.
- Reset asserted mid-burst: immediate return to reset values. After release, the block waits in IDLE for a new trigger.
- I_count is latched at acceptance; later changes have no effect.

Decomposition:
- Package led_flash_pkg:
  - state encoding localparams S_IDLE=2'd0, S_ON=2'd1, S_OFF=2'd2;
  - function t10ms_max(REF_CLK) returning REF_CLK/100-1.
- Sub-module tick_gen_10ms: REF_CLK parameter; ports I_sysclk, I_rstn, I_clr, O_tick.
  - It is the single reusable tick source for this block and future timed UI blocks.
- The FSM, ph_cnt (8 bit) and rem (4 bit) stay in led_flash_ctrl.

Test Plan:
- Common setup: REF_CLK=1000 (tick every 10 cycles), ON_TICKS=2, OFF_TICKS=3, LED_ACT_LOW=0. So ON=20 cycles and OFF=30 cycles.
- Trig with count=3 at cycle 0 -> O_led high for cycles 1-20, 51-70, 101-120, low otherwise; O_busy high cycles 1-120; O_done=1 only at cycle 121.
- Trig with count=0 -> O_busy, O_led and O_done stay 0 for 200 cycles.
- Trig count=2 at cycle 0, trig count=5 at cycle 10 -> burst of exactly 2 flashes (O_done at cycle 71); second trigger has no effect.
- Trig count=4, I_abort pulsed at cycle 60 -> cycle 61: O_led=0, O_busy=0; O_done never asserts. New trig count=1 at cycle 80 -> single 20-cycle flash.
- Trig count=1 repeated in each cycle where O_done=1 -> continuous bursts, each with O_led high for 20 cycles, and O_led=0 for exactly 1 cycle between bursts.
- I_rstn low at cycle 35 of a count=3 burst -> O_led, O_busy and O_done go to 0 asynchronously; stays IDLE after release. Repeat with LED_ACT_LOW=1 -> O_led idles at 1.
